// File: rtl/axis_demux_top.sv
`default_nettype none
// ============================================================================
// Module   : axis_demux_top
// Purpose  : AXI-Stream 1-to-2 packet demultiplexer with a one-beat register
//            slice and a completed-packet counter on each output.
// Revision : 1.0
// ============================================================================
module axis_demux_top #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    output logic                  m0_axis_tlast,
    input  logic                  m0_axis_tready,
    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    output logic                  m1_axis_tlast,
    input  logic                  m1_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_route;
    logic   w_route_nxt;
    logic   w_dest;
    logic   w_accept;

    // Slice storage, index 0 feeds m0 and index 1 feeds m1.
    logic [1:0][DATA_WIDTH-1:0] r_data;
    logic [1:0]                 r_last;
    logic [1:0]                 r_valid;
    logic [1:0][CNT_WIDTH-1:0]  r_cnt;

    logic [1:0] w_mready;
    logic [1:0] w_free;
    logic [1:0] w_xfer;
    logic [1:0] w_load;

    // sel only matters on a packet's first beat; afterwards the latched route wins.
    assign w_dest   = (r_state == ST_IDLE) ? sel : r_route;

    assign w_mready = {m1_axis_tready, m0_axis_tready};
    assign w_free   = ~r_valid | w_mready;
    assign w_xfer   = r_valid & w_mready;

    assign s_axis_tready = ~reset & (w_dest ? w_free[1] : w_free[0]);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_load        = w_accept ? (w_dest ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_route <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !s_axis_tlast) begin
                    w_state_nxt = ST_PKT;
                    w_route_nxt = sel;
                end
            end
            ST_PKT: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A slice is only loaded when it is empty or draining, so a held beat never changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_last  <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= s_axis_tdata;
                    r_last[i]  <= s_axis_tlast;
                    r_valid[i] <= 1'b1;
                end else if (w_xfer[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_xfer[i] && r_last[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    assign m0_axis_tdata  = r_data[0];
    assign m0_axis_tlast  = r_last[0];
    assign m0_axis_tvalid = r_valid[0];
    assign m1_axis_tdata  = r_data[1];
    assign m1_axis_tlast  = r_last[1];
    assign m1_axis_tvalid = r_valid[1];
    assign pkt_cnt0       = r_cnt[0];
    assign pkt_cnt1       = r_cnt[1];
    assign busy           = (r_state == ST_PKT);

endmodule

`default_nettype wire

// File: tb/tb_axis_demux_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_demux_top
// Purpose  : Scoreboard bench for axis_demux_top (counter width 4 for wrap).
// Revision : 1.0
// ============================================================================
module tb_axis_demux_top;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          sel;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m0_axis_tdata;
    logic          m0_axis_tvalid;
    logic          m0_axis_tlast;
    logic          m0_axis_tready;
    logic [DW-1:0] m1_axis_tdata;
    logic          m1_axis_tvalid;
    logic          m1_axis_tlast;
    logic          m1_axis_tready;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic          busy;

    axis_demux_top #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tlast  (m0_axis_tlast),
        .m0_axis_tready (m0_axis_tready),
        .m1_axis_tdata  (m1_axis_tdata),
        .m1_axis_tvalid (m1_axis_tvalid),
        .m1_axis_tlast  (m1_axis_tlast),
        .m1_axis_tready (m1_axis_tready),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .busy           (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired: time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    // Output scoreboard: every master transfer must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            if (m0_axis_tvalid && m0_axis_tready) begin
                n_checks++;
                if (q0.size() == 0) begin
                    $display("FAIL m0_unexpected: got data=%h last=%b, required no beat", m0_axis_tdata, m0_axis_tlast);
                end else begin
                    e = q0.pop_front();
                    if ({m0_axis_tdata, m0_axis_tlast} !== e) $display("FAIL m0_beat: got data=%h last=%b, required data=%h last=%b", m0_axis_tdata, m0_axis_tlast, e.data, e.last);
                    else n_pass++;
                end
            end
            if (m1_axis_tvalid && m1_axis_tready) begin
                n_checks++;
                if (q1.size() == 0) begin
                    $display("FAIL m1_unexpected: got data=%h last=%b, required no beat", m1_axis_tdata, m1_axis_tlast);
                end else begin
                    e = q1.pop_front();
                    if ({m1_axis_tdata, m1_axis_tlast} !== e) $display("FAIL m1_beat: got data=%h last=%b, required data=%h last=%b", m1_axis_tdata, m1_axis_tlast, e.data, e.last);
                    else n_pass++;
                end
            end
        end
    end

    task automatic push_exp(input bit dst, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (dst) q1.push_back(b);
        else     q0.push_back(b);
    endtask

    // Presents one beat and holds it until accepted; leaves tvalid high for back-to-back use.
    task automatic send_beat(input logic s, input logic [DW-1:0] d, input logic l, input bit dst);
        bit done = 1'b0;
        sel           = s;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                push_exp(dst, d, l);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: beat %h not accepted, required acceptance", d);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL %s_drain: pending q0=%0d q1=%0d, required 0/0", name, q0.size(), q1.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        q0.delete();
        q1.delete();
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_counts(input string name, input logic [CW-1:0] e0, input logic [CW-1:0] e1);
        n_checks++;
        if ({pkt_cnt0, pkt_cnt1} !== {e0, e1})
            $display("FAIL %s_counts: got cnt0=%0d cnt1=%0d, required cnt0=%0d cnt1=%0d", name, pkt_cnt0, pkt_cnt1, e0, e1);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({m0_axis_tvalid, m0_axis_tdata, m0_axis_tlast, m1_axis_tvalid, m1_axis_tdata, m1_axis_tlast} !== '0)
            $display("FAIL reset_outputs: got m0 v=%b d=%h m1 v=%b d=%h, required all 0", m0_axis_tvalid, m0_axis_tdata, m1_axis_tvalid, m1_axis_tdata);
        else n_pass++;
        n_checks++;
        if ({pkt_cnt0, pkt_cnt1, busy, s_axis_tready} !== '0)
            $display("FAIL reset_status: got cnt0=%0d cnt1=%0d busy=%b tready=%b, required 0", pkt_cnt0, pkt_cnt1, busy, s_axis_tready);
        else n_pass++;
        #3;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_axis_tready, busy} !== 2'b10)
            $display("FAIL reset_release: got tready=%b busy=%b, required tready=1 busy=0", s_axis_tready, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        int busy_cyc = 0;
        apply_reset();
        m0_axis_tready = 1'b1;
        m1_axis_tready = 1'b1;
        sel = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    s_axis_tdata  = DW'(i + 1);
                    s_axis_tlast  = (i == 3);
                    s_axis_tvalid = 1'b1;
                    @(negedge clk);
                    n_checks++;
                    if (s_axis_tready !== 1'b1) $display("FAIL basic_tready: got %b, required 1", s_axis_tready);
                    else begin
                        n_pass++;
                        push_exp(1'b0, DW'(i + 1), (i == 3));
                    end
                    if (i > 0) begin
                        n_checks++;
                        if ({m0_axis_tvalid, m0_axis_tdata, m0_axis_tlast} !== {1'b1, DW'(i), 1'b0})
                            $display("FAIL basic_latency: got v=%b d=%h l=%b, required v=1 d=%h l=0", m0_axis_tvalid, m0_axis_tdata, m0_axis_tlast, i);
                        else n_pass++;
                    end
                    @(posedge clk);
                    #1;
                end
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                @(negedge clk);
                n_checks++;
                if ({m0_axis_tvalid, m0_axis_tdata, m0_axis_tlast, m1_axis_tvalid} !== {1'b1, DW'(4), 1'b1, 1'b0})
                    $display("FAIL basic_last: got v=%b d=%h l=%b m1v=%b, required v=1 d=4 l=1 m1v=0", m0_axis_tvalid, m0_axis_tdata, m0_axis_tlast, m1_axis_tvalid);
                else n_pass++;
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (busy) busy_cyc++;
                end
            end
        join
        n_checks++;
        if (busy_cyc != 3) $display("FAIL basic_busy: got %0d busy cycles, required 3", busy_cyc);
        else n_pass++;
        wait_drain("basic");
        check_counts("basic", 4'd1, 4'd0);
    endtask

    task automatic test_sel_ignored();
        apply_reset();
        send_beat(1'b0, 32'hA0, 1'b0, 1'b0);
        send_beat(1'b1, 32'hA1, 1'b0, 1'b0);
        send_beat(1'b1, 32'hA2, 1'b0, 1'b0);
        send_beat(1'b1, 32'hA3, 1'b1, 1'b0);
        send_beat(1'b1, 32'hB0, 1'b0, 1'b1);
        send_beat(1'b1, 32'hB1, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_drain("sel_ignored");
        check_counts("sel_ignored", 4'd1, 4'd1);
    endtask

    task automatic test_backpressure();
        apply_reset();
        fork
            begin
                for (int i = 0; i < 5; i++) send_beat(1'b1, DW'(32'h10 + i), (i == 4), 1'b1);
                s_axis_tvalid = 1'b0;
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (m1_axis_tvalid && m1_axis_tdata == 32'h11) seen = 1'b1;
                end
                if (seen) begin
                    m1_axis_tready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        n_checks++;
                        if ({m1_axis_tvalid, m1_axis_tdata} !== {1'b1, 32'h11})
                            $display("FAIL bp_hold: got v=%b d=%h, required v=1 d=11", m1_axis_tvalid, m1_axis_tdata);
                        else n_pass++;
                        n_checks++;
                        if (s_axis_tready !== 1'b0) $display("FAIL bp_tready: got %b, required 0", s_axis_tready);
                        else n_pass++;
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    n_checks++;
                    $display("FAIL bp_trigger: beat 11 not presented on m1, required presented");
                end
                m1_axis_tready = 1'b1;
            end
        join
        wait_drain("backpressure");
        check_counts("backpressure", 4'd0, 4'd1);
    endtask

    task automatic test_alternating();
        int start;
        apply_reset();
        start = cyc;
        for (int i = 0; i < 8; i++) send_beat(i[0], DW'(i), 1'b1, i[0]);
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (cyc - start != 8) $display("FAIL alt_rate: got %0d cycles, required 8", cyc - start);
        else n_pass++;
        wait_drain("alternating");
        check_counts("alternating", 4'd4, 4'd4);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_beat(1'b0, 32'h50, 1'b0, 1'b0);
        send_beat(1'b0, 32'h51, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({m0_axis_tvalid, busy} !== 2'b11) $display("FAIL mid_pre: got v=%b busy=%b, required 1/1", m0_axis_tvalid, busy);
        else n_pass++;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        n_checks++;
        if ({m0_axis_tvalid, busy, s_axis_tready} !== 3'b000)
            $display("FAIL mid_reset: got v=%b busy=%b tready=%b, required 0/0/0", m0_axis_tvalid, busy, s_axis_tready);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_beat(1'b1, 32'h60, 1'b0, 1'b1);
        send_beat(1'b1, 32'h61, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        wait_drain("reset_mid");
        check_counts("reset_mid", 4'd0, 4'd1);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int p = 0; p < 17; p++) send_beat(1'b0, DW'(32'h100 + p), 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        wait_drain("wrap");
        check_counts("wrap", 4'd1, 4'd0);
    endtask

    initial begin
        reset          = 1'b1;
        sel            = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m0_axis_tready = 1'b1;
        m1_axis_tready = 1'b1;
        test_reset();
        test_basic();
        test_sel_ignored();
        test_backpressure();
        test_alternating();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_demux_top.md
# axis_demux_top

AXI-Stream 1-to-2 packet demultiplexer: the receive-side counterpart of the mux_top stream source. It accepts one slave stream and routes whole packets to one of two master streams, chosen by `sel`. Each output has a one-beat register slice, and each output keeps a count of completed packets. It sits between the stream source and two downstream consumers.

## Interface
- `DATA_WIDTH`, 32, width of all tdata buses.
- `CNT_WIDTH`, 16, width of each packet counter.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  1  destination for the next packet: 0 → m0, 1 → m1. Sampled only on a packet's first beat.
- `s_axis_tdata`  in  DATA_WIDTH  input data.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  marks the last beat of a packet.
- `m0_axis_tdata` / `m0_axis_tvalid` / `m0_axis_tlast`  out  DATA_WIDTH/1/1  output 0.
- `m0_axis_tready`  in  1  output 0 ready.
- `m1_axis_tdata` / `m1_axis_tvalid` / `m1_axis_tlast`  out  DATA_WIDTH/1/1  output 1.
- `m1_axis_tready`  in  1  output 1 ready.
- `pkt_cnt0`, `pkt_cnt1`  out  CNT_WIDTH  packets completed on m0 / m1.
- `busy`  out  1  high while a multi-beat packet is in progress.

## Operation
- **Transfer:** a beat transfers on any interface when tvalid & tready are both high at the rising clk edge.
- **FSM IDLE:**
  - Route `dest = sel`.
  - Accepted beat with `s_axis_tlast=0`: latch `route_r <= sel` and go to PKT.
  - Accepted beat with `s_axis_tlast=1` (single-beat packet): stay in IDLE.
- **FSM PKT:**
  - Route `dest = route_r`; `sel` is ignored.
  - Accepted beat with `s_axis_tlast=1`: go to IDLE.
- **busy:** `busy = (state == PKT)`.
- **Output slices:** each output has registers `tdata`, `tlast` and `tvalid`.
  - `s_axis_tready = ~mX_axis_tvalid | mX_axis_tready`, where X = `dest` (combinational ready path).
  - An accepted input beat loads slice `dest` and sets its tvalid.
  - A slice that transfers with no new load clears its tvalid.
  - A slice that transfers while loaded in the same cycle stays valid with the new data.
- **Isolation:** the non-selected slice never loads; it only drains.
- **AXI rule:** once a master tvalid is high, tdata, tlast and tvalid hold stable until the beat transfers.
- **Counters:** `pkt_cnt0` increments on each m0 transfer with tlast=1; `pkt_cnt1` likewise for m1.
  - Width CNT_WIDTH; wraps from all-ones to 0.
  - If both outputs complete a packet in the same cycle, both counters increment.
- **Reset:** asynchronous, effective immediately. Any in-flight beats in the slices are discarded and are not counted.

## Timing
- **Reset values:**
  - All m*_axis_tvalid, tdata and tlast = 0.
  - pkt_cnt0 = pkt_cnt1 = 0; busy = 0; state = IDLE; route_r = 0.
  - `s_axis_tready` is forced to 0 while `reset` is high and equals 1 on the first cycle after release.
- **Latency:** an input beat accepted at edge N appears on its master at edge N (visible in cycle N+1). Fixed 1-cycle latency.
- **Throughput:** 1 beat/cycle sustained while the destination's tready is held high, including back-to-back packets to the same output.
- **Backpressure:** if the destination slice is full and its tready is 0, `s_axis_tready` goes low in that same cycle. Beats are never lost or duplicated.
- **Destination switch between packets:** the next packet's first beat is accepted as soon as the new destination's slice can take it. It does not wait for the previous output to drain, so both outputs may be valid at once.
- **sel change:** a change in the same cycle as a first beat takes effect for that beat. A change during PKT has no effect until the packet ends.

## Test plan
- **Reset:** hold reset=1 for 6 ns with clk period 10 ns.
  - During reset: all outputs = 0 and s_axis_tready = 0.
  - After release: s_axis_tready = 1 and busy = 0.
- **Basic routing:** sel=0, 4-beat packet 0x1..0x4 with tlast on 0x4, m0_tready=1.
  - m0 emits 0x1..0x4 on consecutive cycles, 1 cycle late, tlast only on 0x4.
  - m1_axis_tvalid stays 0; pkt_cnt0=1; busy is high for 3 cycles.
- **sel ignored mid-packet:** sel=0 at beat 1, sel=1 from beat 2 of a 4-beat packet 0xA0..0xA3, then a 2-beat packet 0xB0..0xB1.
  - All 0xA* beats go to m0; 0xB0..0xB1 go to m1.
  - pkt_cnt0=1, pkt_cnt1=1.
- **Backpressure:** sel=1, 5-beat packet 0x10..0x14; drop m1_tready for 3 cycles after 0x11 is presented.
  - m1_tdata holds 0x11 stable; s_axis_tready is low during the stall.
  - Output sequence is exactly 0x10..0x14 with no gaps or duplicates once ready returns.
- **Alternating single-beat packets:** 8 single-beat packets (tlast=1) 0x0..0x7, sel toggling 0,1,0,1… with both treadys high.
  - Even values appear on m0, odd values on m1, one beat per cycle.
  - pkt_cnt0=4, pkt_cnt1=4.
- **Reset mid-packet and counter wrap:**
  - Assert reset after 2 beats of a sel=0 packet: m0_tvalid drops immediately and busy=0; the next packet with sel=1 routes to m1.
  - With CNT_WIDTH=4, send 17 packets to m0: pkt_cnt0 = 1.
